// File: rtl/tilemap_scroll_gen_multi_pkg.sv
// Shared definitions for the multi-layer tilemap scroll/address generator.
// Contents: layer-index width helper, scroll byte positions within a layer's
// 4-byte group, and the scroll-load FSM state encoding.
package tmsg_pkg;

  // Bits needed to number the layers (1 -> 0, 2 -> 1, 4 -> 2).
  function automatic int tmsg_lw(input int layers);
    return (layers >= 4) ? 2 : ((layers == 2) ? 1 : 0);
  endfunction

  localparam int BYTES_PER_LAYER = 4;

  // Position of each scroll byte inside one layer's group.
  localparam logic [1:0] BYTE_HS_LO = 2'd0;
  localparam logic [1:0] BYTE_HS_HI = 2'd1;
  localparam logic [1:0] BYTE_VS_LO = 2'd2;
  localparam logic [1:0] BYTE_VS_HI = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } load_state_t;

endpackage

// File: rtl/tilemap_scroll_gen_multi_if.sv
// Signal bundle between the video timing/CPU side and the tilemap generator.
// master: drives pixel enable, flips, HV counters, scroll byte stream, CPU address.
// slave : returns VRAM address, per-layer tile line, shift strobes, load status.
interface tilemap_scroll_gen_multi_if #(
  parameter int LAYERS  = 2,
  parameter int COLBITS = 6,
  parameter int ROWBITS = 5,
  parameter int CPUAW   = 12
);
  logic                  clk6mpcen_n;
  logic                  hflip;
  logic                  vflip;
  logic [COLBITS+2:0]    hcnt;
  logic [ROWBITS+2:0]    vcnt;
  logic                  line_start;
  logic                  scrl_start;
  logic                  scrl_valid;
  logic [7:0]            gfxdata;
  logic [CPUAW-1:0]      cpu_addr;
  logic [CPUAW-1:0]      vramaddr;
  logic [3*LAYERS-1:0]   tilelineaddr;
  logic [LAYERS-1:0]     shift_n;
  logic                  load_busy;
  logic                  load_err;

  modport master (
    output clk6mpcen_n, hflip, vflip, hcnt, vcnt, line_start, scrl_start,
           scrl_valid, gfxdata, cpu_addr,
    input  vramaddr, tilelineaddr, shift_n, load_busy, load_err
  );

  modport slave (
    input  clk6mpcen_n, hflip, vflip, hcnt, vcnt, line_start, scrl_start,
           scrl_valid, gfxdata, cpu_addr,
    output vramaddr, tilelineaddr, shift_n, load_busy, load_err
  );
endinterface

// File: rtl/tilemap_scroll_gen_multi_bank.sv
// Shadow + active H/V scroll register pair for one tilemap layer.
// Ports: clk/rst, wr_en/wr_sel/wr_dat byte write into shadow, commit copies
// shadow to active; hs/vs are the active scroll values.
module tmsg_scroll_bank
  import tmsg_pkg::*;
#(
  parameter int COLBITS = 6,
  parameter int ROWBITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [1:0]         wr_sel,
  input  logic [7:0]         wr_dat,
  input  logic               commit,
  output logic [COLBITS+2:0] hs,
  output logic [ROWBITS+2:0] vs
);
  localparam int HSW = COLBITS + 3;
  localparam int VSW = ROWBITS + 3;

  logic [HSW-1:0] hs_shadow;
  logic [VSW-1:0] vs_shadow;

  // Bits 0..7 come from the low byte, the rest from the high byte's LSBs;
  // high-byte bits beyond the register width simply have no destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_shadow <= '0;
      vs_shadow <= '0;
      hs        <= '0;
      vs        <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < HSW; b++)
          if (wr_sel == ((b < 8) ? BYTE_HS_LO : BYTE_HS_HI))
            hs_shadow[b] <= wr_dat[b % 8];
        for (int b = 0; b < VSW; b++)
          if (wr_sel == ((b < 8) ? BYTE_VS_LO : BYTE_VS_HI))
            vs_shadow[b] <= wr_dat[b % 8];
      end
      if (commit) begin
        hs <= hs_shadow;
        vs <= vs_shadow;
      end
    end
  end
endmodule

// File: rtl/tilemap_scroll_gen_multi.sv
// Multi-layer tilemap address generator: streamed scroll load, line-start
// commit, CPU/layer time-multiplexed VRAM address, tile line and shift strobes.
// Ports: i_EMU_MCLK clock, i_EMU_RST sync reset, bus (slave modport) for the rest.
module tilemap_scroll_gen_multi
  import tmsg_pkg::*;
#(
  parameter int LAYERS  = 2,
  parameter int COLBITS = 6,
  parameter int ROWBITS = 5,
  parameter int CPUAW   = 12
) (
  input logic                   i_EMU_MCLK,
  input logic                   i_EMU_RST,
  tilemap_scroll_gen_multi_if.slave bus
);
  localparam int LW   = tmsg_lw(LAYERS);
  localparam int NB   = BYTES_PER_LAYER * LAYERS;
  localparam int IDXW = LW + 2;
  localparam int HSW  = COLBITS + 3;
  localparam int VSW  = ROWBITS + 3;

  logic cen;
  assign cen = ~bus.clk6mpcen_n;

  logic [HSW-1:0] fh;
  logic [VSW-1:0] fv;
  assign fh = bus.hcnt ^ {HSW{bus.hflip}};
  assign fv = bus.vcnt ^ {VSW{bus.vflip}};

  // ---------------- scroll load FSM ----------------
  load_state_t     state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            err_q, err_d;
  logic            wr_en, commit;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.scrl_start) begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end
        end
        ST_LOAD: begin
          // A line start here means the sequence missed its commit window.
          if (bus.line_start) err_d = 1'b1;
          if (bus.scrl_start) begin
            idx_d = '0;
          end else if (bus.scrl_valid) begin
            wr_en = 1'b1;
            if (idx_q == IDXW'(NB - 1)) begin
              state_d = ST_READY;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDXW'(1);
            end
          end
        end
        ST_READY: begin
          if (bus.line_start) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else if (bus.scrl_start) begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.load_busy = (state_q == ST_LOAD);
  assign bus.load_err  = err_q;

  // ---------------- per-layer scroll banks ----------------
  logic [HSW-1:0] hs_act [LAYERS];
  logic [VSW-1:0] vs_act [LAYERS];

  for (genvar g = 0; g < LAYERS; g++) begin : g_bank
    tmsg_scroll_bank #(
      .COLBITS(COLBITS),
      .ROWBITS(ROWBITS)
    ) u_bank (
      .clk   (i_EMU_MCLK),
      .rst   (i_EMU_RST),
      .wr_en (wr_en && ((idx_q >> 2) == IDXW'(g))),
      .wr_sel(idx_q[1:0]),
      .wr_dat(bus.gfxdata),
      .commit(commit),
      .hs    (hs_act[g]),
      .vs    (vs_act[g])
    );
  end

  // ---------------- slot decode and address build ----------------
  logic [2:0] slot, lay;
  logic       cpu_slot;
  assign slot     = bus.hcnt[2:0];
  assign cpu_slot = ~slot[2-LW];
  assign lay      = slot >> (3 - LW);   // always 0 with a single layer

  logic [COLBITS-1:0] sel_hcol;
  logic [VSW-1:0]     sel_vs;
  always_comb begin
    sel_hcol = '0;
    sel_vs   = '0;
    for (int k = 0; k < LAYERS; k++) begin
      if (lay == 3'(k)) begin
        sel_hcol = hs_act[k][HSW-1:3];
        sel_vs   = vs_act[k];
      end
    end
  end

  // Column adds only the tile parts (fine H goes to the shift strobe);
  // row uses the full V sum so fine-V carry moves to the next tile row.
  logic [COLBITS-1:0] col;
  logic [VSW-1:0]     vsum;
  logic [CPUAW-1:0]   lay_addr;
  assign col      = sel_hcol + fh[HSW-1:3];
  assign vsum     = sel_vs + fv;
  assign lay_addr = CPUAW'({vsum[VSW-1:3], col}) | (CPUAW'(lay) << (ROWBITS + COLBITS));

  logic [CPUAW-1:0]    vramaddr_q;
  logic [3*LAYERS-1:0] tileline_q;
  logic [LAYERS-1:0]   shift_n_q;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      vramaddr_q <= '0;
      tileline_q <= '0;
      shift_n_q  <= '1;
    end else if (cen) begin
      vramaddr_q <= cpu_slot ? bus.cpu_addr : lay_addr;
      for (int k = 0; k < LAYERS; k++) begin
        if (!cpu_slot && (lay == 3'(k)))
          tileline_q[3*k +: 3] <= vsum[2:0];
        shift_n_q[k] <= ((hs_act[k][2:0] + fh[2:0]) != 3'd7);
      end
    end
  end

  assign bus.vramaddr     = vramaddr_q;
  assign bus.tilelineaddr = tileline_q;
  assign bus.shift_n      = shift_n_q;
endmodule

// File: tb/tb_tilemap_scroll_gen_multi.sv
// Directed bench for tilemap_scroll_gen_multi: a 2-layer instance for load,
// commit, wrap, flip and tearing cases, and a 4-layer instance for slot decode.
module tb_tilemap_scroll_gen_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tilemap_scroll_gen_multi_if #(.LAYERS(2), .COLBITS(6), .ROWBITS(5), .CPUAW(12)) bus2 ();
  tilemap_scroll_gen_multi_if #(.LAYERS(4), .COLBITS(5), .ROWBITS(5), .CPUAW(12)) bus4 ();

  tilemap_scroll_gen_multi #(.LAYERS(2), .COLBITS(6), .ROWBITS(5), .CPUAW(12)) dut (
    .i_EMU_MCLK(clk),
    .i_EMU_RST (rst),
    .bus       (bus2)
  );

  tilemap_scroll_gen_multi #(.LAYERS(4), .COLBITS(5), .ROWBITS(5), .CPUAW(12)) dut4 (
    .i_EMU_MCLK(clk),
    .i_EMU_RST (rst),
    .bus       (bus4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stream [16];

  task automatic set2(input logic [8:0] hs0, input logic [7:0] vs0,
                      input logic [8:0] hs1, input logic [7:0] vs1);
    stream[0] = hs0[7:0]; stream[1] = {7'd0, hs0[8]}; stream[2] = vs0; stream[3] = 8'd0;
    stream[4] = hs1[7:0]; stream[5] = {7'd0, hs1[8]}; stream[6] = vs1; stream[7] = 8'd0;
  endtask

  task automatic start2();
    bus2.scrl_start = 1'b1; tick(); bus2.scrl_start = 1'b0;
  endtask

  task automatic send2(input int first, input int last);
    bus2.scrl_valid = 1'b1;
    for (int i = first; i <= last; i++) begin
      bus2.gfxdata = stream[i];
      tick();
    end
    bus2.scrl_valid = 1'b0;
  endtask

  task automatic commit2();
    bus2.line_start = 1'b1; tick(); bus2.line_start = 1'b0;
  endtask

  task automatic look2(input logic [8:0] h, input logic [7:0] v);
    bus2.hcnt = h; bus2.vcnt = v; tick();
  endtask

  initial begin
    bus2.clk6mpcen_n = 1'b0; bus2.hflip = 1'b0; bus2.vflip = 1'b0;
    bus2.hcnt = '0; bus2.vcnt = '0; bus2.line_start = 1'b0; bus2.scrl_start = 1'b0;
    bus2.scrl_valid = 1'b0; bus2.gfxdata = '0; bus2.cpu_addr = 12'hABC;
    bus4.clk6mpcen_n = 1'b0; bus4.hflip = 1'b0; bus4.vflip = 1'b0;
    bus4.hcnt = '0; bus4.vcnt = '0; bus4.line_start = 1'b0; bus4.scrl_start = 1'b0;
    bus4.scrl_valid = 1'b0; bus4.gfxdata = '0; bus4.cpu_addr = '0;

    // Reset state
    rst = 1'b1; tick(); tick();
    check("rst_vram", bus2.vramaddr, 12'h000);
    check("rst_tline", bus2.tilelineaddr, 6'h00);
    check("rst_shift", bus2.shift_n, 2'b11);
    check("rst_busy", bus2.load_busy, 1'b0);
    check("rst_err", bus2.load_err, 1'b0);
    rst = 1'b0;

    // No load: zero scroll
    look2(9'h003, 8'h00);
    check("t1_layer0", bus2.vramaddr, 12'h000);
    check("t1_shift", bus2.shift_n, 2'b11);
    look2(9'h000, 8'h00);
    check("t1_cpu", bus2.vramaddr, 12'hABC);
    look2(9'h007, 8'h00);
    check("t1_layer1", bus2.vramaddr, 12'h800);
    check("t1_shift7", bus2.shift_n, 2'b00);

    // Basic load and commit
    set2(9'h01F, 8'h0F, 9'h000, 8'h00);
    start2();
    check("t2_busy", bus2.load_busy, 1'b1);
    send2(0, 7);
    check("t2_ready", bus2.load_busy, 1'b0);
    commit2();
    look2(9'h003, 8'h00);
    check("t2_addr", bus2.vramaddr, 12'h043);
    check("t2_tline", bus2.tilelineaddr, 6'h07);
    check("t2_shift_h3", bus2.shift_n, 2'b11);
    look2(9'h000, 8'h00);
    check("t2_shift_h0", bus2.shift_n, 2'b10);

    // Column wrap and flips
    set2(9'h1F8, 8'h00, 9'h000, 8'h00);
    start2(); send2(0, 7); commit2();
    look2(9'h012, 8'h00);
    check("t3_wrap", bus2.vramaddr, 12'h001);
    check("t3_tline", bus2.tilelineaddr, 6'h00);
    bus2.hflip = 1'b1;
    look2(9'h012, 8'h00);
    check("t3_hflip", bus2.vramaddr, 12'h03C);
    bus2.hflip = 1'b0; bus2.vflip = 1'b1;
    look2(9'h012, 8'h00);
    check("t3_vflip", bus2.vramaddr, 12'h7C1);
    check("t3_vflip_tl", bus2.tilelineaddr, 6'h07);
    bus2.vflip = 1'b0;

    // Line start during an incomplete sequence
    set2(9'h055, 8'h22, 9'h10A, 8'h3C);
    start2(); send2(0, 2);
    commit2();
    check("t4_err", bus2.load_err, 1'b1);
    check("t4_busy", bus2.load_busy, 1'b1);
    look2(9'h012, 8'h00);
    check("t4_old", bus2.vramaddr, 12'h001);
    send2(3, 7);
    check("t4_ready", bus2.load_busy, 1'b0);
    look2(9'h012, 8'h00);
    check("t4_uncommitted", bus2.vramaddr, 12'h001);
    commit2();
    look2(9'h012, 8'h00);
    check("t4_l0", bus2.vramaddr, 12'h10C);
    check("t4_l0_tl", bus2.tilelineaddr, 6'h02);
    look2(9'h016, 8'h00);
    check("t4_l1", bus2.vramaddr, 12'h9E3);
    check("t4_l1_tl", bus2.tilelineaddr, 6'h22);
    check("t4_err_sticky", bus2.load_err, 1'b1);

    // Mid-line load, commit withheld
    set2(9'h000, 8'h00, 9'h000, 8'h00);
    start2(); send2(0, 7);
    look2(9'h012, 8'h00);
    check("t5_hold_a", bus2.vramaddr, 12'h10C);
    look2(9'h03A, 8'h00);
    check("t5_hold_b", bus2.vramaddr, 12'h111);
    bus2.hcnt = 9'h012;
    commit2();
    check("t5_commit_cen", bus2.vramaddr, 12'h10C);
    look2(9'h012, 8'h00);
    check("t5_after", bus2.vramaddr, 12'h002);

    // Pixel enable gating
    bus2.clk6mpcen_n = 1'b1; bus2.hcnt = 9'h000; bus2.cpu_addr = 12'h123;
    start2();
    check("cen_hold", bus2.vramaddr, 12'h002);
    check("cen_no_start", bus2.load_busy, 1'b0);
    bus2.clk6mpcen_n = 1'b0;
    tick();
    check("cen_resume", bus2.vramaddr, 12'h123);

    // Reset mid-load
    start2(); send2(0, 1);
    check("rl_busy", bus2.load_busy, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rl_idle", bus2.load_busy, 1'b0);
    check("rl_err_clr", bus2.load_err, 1'b0);
    look2(9'h012, 8'h00);
    check("rl_zero", bus2.vramaddr, 12'h002);

    // Four-layer slot decode
    bus4.hcnt = 8'h05; bus4.cpu_addr = 12'h5A5; tick();
    check("t6_layer2", bus4.vramaddr, 12'h800);
    bus4.hcnt = 8'h04; tick();
    check("t6_cpu", bus4.vramaddr, 12'h5A5);
    for (int i = 0; i < 16; i++) stream[i] = 8'h00;
    stream[8] = 8'h1B; stream[10] = 8'h29;
    bus4.scrl_start = 1'b1; tick(); bus4.scrl_start = 1'b0;
    bus4.scrl_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus4.gfxdata = stream[i];
      tick();
    end
    bus4.scrl_valid = 1'b0;
    check("t6_ready", bus4.load_busy, 1'b0);
    bus4.line_start = 1'b1; tick(); bus4.line_start = 1'b0;
    bus4.hcnt = 8'h0D; tick();
    check("t6_l2_scroll", bus4.vramaddr, 12'h8A4);
    check("t6_l2_tl", bus4.tilelineaddr, 12'h040);
    bus4.hcnt = 8'h0F; tick();
    check("t6_layer3", bus4.vramaddr, 12'hC01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
